run_length_coder: RTL and testbench

- Run-mode bitstream stage that sits directly downstream of the run counter. It consumes one per-pixel run event at a time: run continues, run interrupted, or run reaches end of line.
- It keeps the JPEG-LS RUNindex state and the partial run count, and emits run-length codewords per ITU-T T.87 A.7.1.1 to the bit packer.
- Interruption codewords also carry the value of J that the interruption-sample coder needs.

---
 rtl/run_length_coder.sv | 172 +++++++++++++++++
 tb/tb_run_length_coder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/run_length_coder.sv
// run_length_coder
//   JPEG-LS run-mode bitstream stage. Consumes one run event per handshake
//   (RUN / INTR / EOL), maintains RUNindex and the partial run count, and
//   emits run-length codewords (right-aligned, MSB first) to the bit packer.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   start_enc  synchronous scan start; clears state, drops any event this cycle
//   ev_valid / ev_ready / ev_type   event handshake (0 RUN, 1 INTR, 2 EOL, 3 reserved)
//   code_valid / code_ready         codeword handshake (single output register)
//   code_bits  codeword, right-aligned
//   code_len   number of valid bits in code_bits (1..16)
//   run_index  current RUNindex (value before this cycle's update)
//   j_value    J[run_index]
//
// Optional build macro RUN_STATS_EN adds stat_ones, stat_intr, stat_maxidx.
module run_length_coder #(
  parameter int runcount_length = 16,
  parameter int code_length     = 16,
  parameter int codelen_length  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_enc,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic [1:0]                ev_type,
  output logic                      code_valid,
  input  logic                      code_ready,
  output logic [code_length-1:0]    code_bits,
  output logic [codelen_length-1:0] code_len,
  output logic [4:0]                run_index,
  output logic [3:0]                j_value
`ifdef RUN_STATS_EN
  ,
  output logic [15:0]               stat_ones,
  output logic [15:0]               stat_intr,
  output logic [4:0]                stat_maxidx
`endif
);

  typedef enum logic [1:0] {
    EV_RUN  = 2'd0,
    EV_INTR = 2'd1,
    EV_EOL  = 2'd2,
    EV_RSVD = 2'd3
  } ev_kind_t;

  logic [runcount_length-1:0] cnt, cnt_nx, cnt_inc, seg;
  logic [4:0]                 idx_nx;
  logic                       accept, emit, emit_one, emit_intr;
  logic [code_length-1:0]     bits_nx;
  logic [codelen_length-1:0]  len_nx;

  // J table
  always_comb begin
    unique case (run_index)
      5'd0,  5'd1,  5'd2,  5'd3:  j_value = 4'd0;
      5'd4,  5'd5,  5'd6,  5'd7:  j_value = 4'd1;
      5'd8,  5'd9,  5'd10, 5'd11: j_value = 4'd2;
      5'd12, 5'd13, 5'd14, 5'd15: j_value = 4'd3;
      5'd16, 5'd17:               j_value = 4'd4;
      5'd18, 5'd19:               j_value = 4'd5;
      5'd20, 5'd21:               j_value = 4'd6;
      5'd22, 5'd23:               j_value = 4'd7;
      default:                    j_value = 4'(run_index - 5'd16);
    endcase
  end

  assign ev_ready = !start_enc && (!code_valid || code_ready);
  assign accept   = ev_valid && ev_ready;
  assign seg      = runcount_length'(1) << j_value;
  assign cnt_inc  = cnt + runcount_length'(1);

  always_comb begin
    cnt_nx    = cnt;
    idx_nx    = run_index;
    emit      = 1'b0;
    emit_one  = 1'b0;
    emit_intr = 1'b0;
    bits_nx   = '0;
    len_nx    = '0;
    if (accept) begin
      unique case (ev_kind_t'(ev_type))
        EV_RUN: begin
          if (cnt_inc == seg) begin
            emit     = 1'b1;
            emit_one = 1'b1;
            bits_nx  = code_length'(1);
            len_nx   = codelen_length'(1);
            cnt_nx   = '0;
            idx_nx   = (run_index == 5'd31) ? 5'd31 : run_index + 5'd1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        EV_EOL: begin
          emit     = 1'b1;
          emit_one = 1'b1;
          bits_nx  = code_length'(1);
          len_nx   = codelen_length'(1);
          cnt_nx   = '0;
          if (cnt_inc == seg)
            idx_nx = (run_index == 5'd31) ? 5'd31 : run_index + 5'd1;
        end
        EV_INTR: begin
          // leading '0' is implicit: cnt < 2^J, so bit J of the field is zero
          emit      = 1'b1;
          emit_intr = 1'b1;
          bits_nx   = code_length'(cnt);
          len_nx    = codelen_length'(j_value) + codelen_length'(1);
          cnt_nx    = '0;
          idx_nx    = (run_index == 5'd0) ? 5'd0 : run_index - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_valid <= 1'b0;
      code_bits  <= '0;
      code_len   <= '0;
      run_index  <= '0;
      cnt        <= '0;
    end else if (start_enc) begin
      code_valid <= 1'b0;
      run_index  <= '0;
      cnt        <= '0;
    end else begin
      cnt       <= cnt_nx;
      run_index <= idx_nx;
      if (accept) begin
        code_valid <= emit;
        if (emit) begin
          code_bits <= bits_nx;
          code_len  <= len_nx;
        end
      end else if (code_ready) begin
        code_valid <= 1'b0;
      end
    end
  end

`ifdef RUN_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ones   <= '0;
      stat_intr   <= '0;
      stat_maxidx <= '0;
    end else if (start_enc) begin
      stat_ones   <= '0;
      stat_intr   <= '0;
      stat_maxidx <= '0;
    end else begin
      if (emit_one && stat_ones != 16'hFFFF) stat_ones <= stat_ones + 16'd1;
      if (emit_intr && stat_intr != 16'hFFFF) stat_intr <= stat_intr + 16'd1;
      if (idx_nx > stat_maxidx) stat_maxidx <= idx_nx;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_reserved_event: assert property (
    @(posedge clk) disable iff (!reset)
    !(ev_valid && ev_ready && ev_type == 2'd3)
  ) else $error("reserved ev_type accepted");
`endif

endmodule

// File: tb/tb_run_length_coder.sv
module tb_run_length_coder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_enc;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_type;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] code_bits;
  logic [4:0]  code_len;
  logic [4:0]  run_index;
  logic [3:0]  j_value;
`ifdef RUN_STATS_EN
  logic [15:0] stat_ones, stat_intr;
  logic [4:0]  stat_maxidx;
`endif

  run_length_coder #(
    .runcount_length(16),
    .code_length(16),
    .codelen_length(5)
  ) dut (
    .clk(clk), .reset(reset), .start_enc(start_enc),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .code_valid(code_valid), .code_ready(code_ready),
    .code_bits(code_bits), .code_len(code_len),
    .run_index(run_index), .j_value(j_value)
`ifdef RUN_STATS_EN
    , .stat_ones(stat_ones), .stat_intr(stat_intr), .stat_maxidx(stat_maxidx)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference state
  int jt[32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,
                 4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};
  int m_idx, m_cnt, m_bits, m_len;
  bit m_valid;
  int m_ones, m_intr, m_maxidx;
  int n_seen;   // codewords actually taken downstream

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_cnt = 0; m_valid = 0;
    m_ones = 0; m_intr = 0; m_maxidx = 0;
  endtask

  // Compare DUT against model at the negedge, then advance the model by the
  // event that the coming posedge will consume.
  task automatic step();
    bit exp_ready, acc, em;
    int seg;
    @(negedge clk);
    exp_ready = !start_enc && (!m_valid || code_ready);
    check_eq("ev_ready", ev_ready, exp_ready);
    check_eq("code_valid", code_valid, m_valid);
    if (m_valid) begin
      check_eq("code_bits", code_bits, m_bits);
      check_eq("code_len", code_len, m_len);
    end
    check_eq("run_index", run_index, m_idx);
    check_eq("j_value", j_value, jt[m_idx]);
`ifdef RUN_STATS_EN
    check_eq("stat_ones", stat_ones, m_ones);
    check_eq("stat_intr", stat_intr, m_intr);
    check_eq("stat_maxidx", stat_maxidx, m_maxidx);
`endif
    if (code_valid && code_ready) n_seen++;
    if (start_enc) begin
      model_clear();
    end else begin
      acc = ev_valid && exp_ready;
      em  = 0;
      if (acc) begin
        seg = 1 << jt[m_idx];
        case (ev_type)
          2'd0: begin
            if (m_cnt + 1 == seg) begin
              em = 1; m_bits = 1; m_len = 1; m_cnt = 0;
              if (m_idx < 31) m_idx++;
              if (m_ones < 65535) m_ones++;
            end else m_cnt++;
          end
          2'd2: begin
            em = 1; m_bits = 1; m_len = 1;
            if (m_cnt + 1 == seg && m_idx < 31) m_idx++;
            m_cnt = 0;
            if (m_ones < 65535) m_ones++;
          end
          2'd1: begin
            em = 1; m_bits = m_cnt; m_len = jt[m_idx] + 1;
            m_cnt = 0;
            if (m_idx > 0) m_idx--;
            if (m_intr < 65535) m_intr++;
          end
          default: ;
        endcase
        if (m_idx > m_maxidx) m_maxidx = m_idx;
        m_valid = em;
      end else if (code_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit v, input logic [1:0] t, input bit r);
    start_enc = s; ev_valid = v; ev_type = t; code_ready = r;
  endtask

  initial begin
    int r;
    int guard;
    bit reached;
    reset = 1'b0;
    drive(0, 0, 2'd0, 1);
    model_clear();
    n_seen = 0;
    #12;
    check_eq("rst_code_valid", code_valid, 0);
    check_eq("rst_code_bits", code_bits, 0);
    check_eq("rst_code_len", code_len, 0);
    check_eq("rst_run_index", run_index, 0);
    check_eq("rst_ev_ready", ev_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // backpressure: produce a codeword, then stall with an event waiting
    drive(0, 1, 2'd2, 1); step();
    drive(0, 1, 2'd0, 0); step();
    drive(0, 1, 2'd0, 0); step();
    drive(0, 1, 2'd0, 1); step();
    drive(0, 0, 2'd0, 1); step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom % 8;
      drive(($urandom % 64) == 0, ($urandom % 4) != 0,
            (r < 5) ? 2'd0 : (r < 7) ? 2'd2 : 2'd1, ($urandom % 4) != 0);
      step();
    end

    // saturate RUNindex at 31 then run one full 32768 segment
    drive(1, 0, 2'd0, 1); step();
    reached = 0;
    guard = 0;
    while (!reached && guard < 40000) begin
      drive(0, 1, 2'd0, 1); step();
      reached = (m_idx == 31);
      guard++;
    end
    check_eq("reach_idx31", reached, 1);
    drive(0, 0, 2'd0, 1); step();
    n_seen = 0;
    for (int i = 0; i < 32768; i++) begin
      drive(0, 1, 2'd0, 1); step();
    end
    drive(0, 0, 2'd0, 1); step();
    check_eq("seg32768_count", n_seen, 1);
    check_eq("idx_sat31", run_index, 31);

    // a few more random events after saturation, then start_enc pulse
    for (int i = 0; i < 50; i++) begin
      r = $urandom % 8;
      drive(0, 1, (r < 5) ? 2'd0 : (r < 7) ? 2'd2 : 2'd1, 1);
      step();
    end
    drive(0, 1, 2'd2, 1); step();
    drive(1, 1, 2'd1, 1); step();
    drive(0, 0, 2'd0, 1); step();
    check_eq("start_idx", run_index, 0);
    check_eq("start_valid", code_valid, 0);

    // reset mid-stream with a pending codeword
    drive(0, 1, 2'd2, 0); step();
    check_eq("pend_valid", code_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", code_valid, 0);
    check_eq("arst_bits", code_bits, 0);
    check_eq("arst_len", code_len, 0);
    check_eq("arst_idx", run_index, 0);
    model_clear();
    drive(0, 0, 2'd0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1, 2'd1, 1); step();
    drive(0, 0, 2'd0, 1); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
